// File: rtl/axi4_sram_slave_if.sv
// AXI4 bus bundle between a master and the SRAM-backed responder.
// Member names keep the S_AXI_* bus names so waveforms match the bus documentation.
interface axi4_sram_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    // Write address channel
    logic [ID_W-1:0]     S_AXI_AWID;
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [7:0]          S_AXI_AWLEN;
    logic [2:0]          S_AXI_AWSIZE;
    logic [1:0]          S_AXI_AWBURST;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    // Write data channel
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WLAST;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    // Write response channel
    logic [ID_W-1:0]     S_AXI_BID;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    // Read address channel
    logic [ID_W-1:0]     S_AXI_ARID;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [7:0]          S_AXI_ARLEN;
    logic [2:0]          S_AXI_ARSIZE;
    logic [1:0]          S_AXI_ARBURST;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    // Read data channel
    logic [ID_W-1:0]     S_AXI_RID;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RLAST;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 responder in front of a byte-strobed synchronous SRAM. One read burst
// and one write burst may be in flight at once, each on its own FSM.
module axi4_sram_slave #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 64,
    parameter int                ID_W      = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                DEPTH     = 8192
) (
    input logic              clk,
    input logic              rst_n,
    axi4_sram_slave_if.slave s_axi
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    // One bit wider than the address so a window ending at the top of the space still compares correctly.
    localparam logic [ADDR_W:0] END_ADDR = {1'b0, BASE_ADDR} + (ADDR_W+1)'(DEPTH * BYTES);

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_BURST} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >= BASE_ADDR) && ({1'b0, a} < END_ADDR);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> OFF_W);
    endfunction

    // Illegal bursts answer SLVERR on every beat and never touch the array.
    function automatic logic burst_ok(input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
        logic ok;
        ok = (burst != BURST_RSVD) && (size <= 3'(OFF_W));
        if (burst == BURST_WRAP)
            ok = ok && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return ok;
    endfunction

    // Address of the beat following 'a'; WRAP stays inside its (len+1)<<size aligned window.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                                    input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_W-1:0] inc;
        logic [ADDR_W-1:0] mask;
        logic [ADDR_W-1:0] res;
        inc  = a + (ADDR_W'(1) << size);
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        if (burst == BURST_FIXED)
            res = a;
        else if (burst == BURST_WRAP)
            res = (a & ~mask) | (inc & mask);
        else
            res = inc;
        return res;
    endfunction

    // Control state
    logic        r_alive;
    rd_state_e   r_rd_state, w_rd_state_nxt;
    wr_state_e   r_wr_state, w_wr_state_nxt;

    // Read channel registers
    logic [ID_W-1:0]   r_ar_id;
    logic [ADDR_W-1:0] r_ar_addr;
    logic [7:0]        r_ar_len;
    logic [2:0]        r_ar_size;
    logic [1:0]        r_ar_burst;
    logic [7:0]        r_rd_cnt;
    logic              r_rvalid;
    logic              r_rlast;
    logic              r_rerr;
    logic [DATA_W-1:0] r_mem_q;

    // Write channel registers
    logic [ID_W-1:0]   r_aw_id;
    logic [ADDR_W-1:0] r_aw_addr;
    logic [7:0]        r_aw_len;
    logic [2:0]        r_aw_size;
    logic [1:0]        r_aw_burst;
    logic [7:0]        r_wr_cnt;
    logic              r_wr_err;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Combinational handshakes and datapath
    logic              w_arready, w_awready, w_wready, w_bvalid;
    logic              w_ar_hs, w_r_hs, w_rd_adv, w_rd_fetch;
    logic [ADDR_W-1:0] w_rd_next, w_rd_fetch_addr;
    logic              w_aw_hs, w_w_hs, w_wr_last_beat, w_wr_en;
    logic [ADDR_W-1:0] w_wr_next;

    assign w_ar_hs         = s_axi.S_AXI_ARVALID & w_arready;
    assign w_r_hs          = r_rvalid & s_axi.S_AXI_RREADY;
    assign w_rd_adv        = w_r_hs & ~r_rlast;
    assign w_rd_next       = next_addr(r_ar_addr, r_ar_len, r_ar_size, r_ar_burst);
    assign w_rd_fetch_addr = w_ar_hs ? s_axi.S_AXI_ARADDR : w_rd_next;
    assign w_rd_fetch      = w_ar_hs | w_rd_adv;

    assign w_aw_hs        = s_axi.S_AXI_AWVALID & w_awready;
    assign w_w_hs         = s_axi.S_AXI_WVALID & w_wready;
    assign w_wr_last_beat = (r_wr_cnt == r_aw_len);
    assign w_wr_next      = next_addr(r_aw_addr, r_aw_len, r_aw_size, r_aw_burst);
    assign w_wr_en        = w_w_hs & burst_ok(r_aw_len, r_aw_size, r_aw_burst) & in_range(r_aw_addr);

    // FSM state registers; r_alive holds both READY outputs low until the first edge after reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive    <= 1'b0;
            r_rd_state <= R_IDLE;
            r_wr_state <= W_IDLE;
        end else begin
            r_alive    <= 1'b1;
            r_rd_state <= w_rd_state_nxt;
            r_wr_state <= w_wr_state_nxt;
        end
    end

    // Read FSM next state and ARREADY.
    // NOTE: every output is given a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_arready      = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                w_arready = r_alive;
                if (s_axi.S_AXI_ARVALID && r_alive)
                    w_rd_state_nxt = R_BURST;
            end
            R_BURST: begin
                if (w_r_hs && r_rlast)
                    w_rd_state_nxt = R_IDLE;
            end
        endcase
    end

    // Read burst bookkeeping and registered R-channel flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ar_id    <= '0;
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
            r_ar_size  <= '0;
            r_ar_burst <= '0;
            r_rd_cnt   <= '0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rerr     <= 1'b0;
        end else if (w_ar_hs) begin
            r_ar_id    <= s_axi.S_AXI_ARID;
            r_ar_addr  <= s_axi.S_AXI_ARADDR;
            r_ar_len   <= s_axi.S_AXI_ARLEN;
            r_ar_size  <= s_axi.S_AXI_ARSIZE;
            r_ar_burst <= s_axi.S_AXI_ARBURST;
            r_rd_cnt   <= '0;
            r_rvalid   <= 1'b1;
            r_rlast    <= (s_axi.S_AXI_ARLEN == 8'd0);
            r_rerr     <= !burst_ok(s_axi.S_AXI_ARLEN, s_axi.S_AXI_ARSIZE, s_axi.S_AXI_ARBURST)
                          || !in_range(s_axi.S_AXI_ARADDR);
        end else if (w_rd_adv) begin
            r_ar_addr <= w_rd_next;
            r_rd_cnt  <= r_rd_cnt + 8'd1;
            r_rlast   <= ((r_rd_cnt + 8'd1) == r_ar_len);
            r_rerr    <= !burst_ok(r_ar_len, r_ar_size, r_ar_burst) || !in_range(w_rd_next);
        end else if (w_r_hs) begin
            r_rvalid <= 1'b0;
        end
    end

    // Write FSM next state and W/AW/B handshake outputs.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_awready      = 1'b0;
        w_wready       = 1'b0;
        w_bvalid       = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                w_awready = r_alive;
                if (s_axi.S_AXI_AWVALID && r_alive)
                    w_wr_state_nxt = W_DATA;
            end
            W_DATA: begin
                w_wready = 1'b1;
                if (s_axi.S_AXI_WVALID && w_wr_last_beat)
                    w_wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (s_axi.S_AXI_BREADY)
                    w_wr_state_nxt = W_IDLE;
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    // Write burst bookkeeping and sticky error flag for BRESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_id    <= '0;
            r_aw_addr  <= '0;
            r_aw_len   <= '0;
            r_aw_size  <= '0;
            r_aw_burst <= '0;
            r_wr_cnt   <= '0;
            r_wr_err   <= 1'b0;
        end else if (w_aw_hs) begin
            r_aw_id    <= s_axi.S_AXI_AWID;
            r_aw_addr  <= s_axi.S_AXI_AWADDR;
            r_aw_len   <= s_axi.S_AXI_AWLEN;
            r_aw_size  <= s_axi.S_AXI_AWSIZE;
            r_aw_burst <= s_axi.S_AXI_AWBURST;
            r_wr_cnt   <= '0;
            r_wr_err   <= !burst_ok(s_axi.S_AXI_AWLEN, s_axi.S_AXI_AWSIZE, s_axi.S_AXI_AWBURST);
        end else if (w_w_hs) begin
            r_wr_err <= r_wr_err || !in_range(r_aw_addr) || (s_axi.S_AXI_WLAST != w_wr_last_beat);
            if (!w_wr_last_beat) begin
                r_aw_addr <= w_wr_next;
                r_wr_cnt  <= r_wr_cnt + 8'd1;
            end
        end
    end

    // SRAM array: byte-strobed write port and registered read port; a same-word read sees the old data.
    // NOTE: the array and its read register have no reset; contents survive reset and RDATA is gated below instead.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (s_axi.S_AXI_WSTRB[b])
                    r_mem[word_idx(r_aw_addr)][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
            end
        end
        if (w_rd_fetch)
            r_mem_q <= r_mem[word_idx(w_rd_fetch_addr)];
    end

    assign s_axi.S_AXI_ARREADY = w_arready;
    assign s_axi.S_AXI_RID     = r_ar_id;
    assign s_axi.S_AXI_RDATA   = (r_rvalid && !r_rerr) ? r_mem_q : '0;
    assign s_axi.S_AXI_RRESP   = (r_rvalid && r_rerr) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi.S_AXI_RLAST   = r_rvalid & r_rlast;
    assign s_axi.S_AXI_RVALID  = r_rvalid;

    assign s_axi.S_AXI_AWREADY = w_awready;
    assign s_axi.S_AXI_WREADY  = w_wready;
    assign s_axi.S_AXI_BID     = r_aw_id;
    assign s_axi.S_AXI_BRESP   = (w_bvalid && r_wr_err) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi.S_AXI_BVALID  = w_bvalid;
endmodule
